redmule_castin_stream: RTL and testbench
========================================

// Module: redmule_castin_stream
// PURPOSE
// Widening cast stage on the load path, mirroring the store-side narrowing cast. Takes
// DATA_W-bit memory beats of packed FP8 elements (E5M2 or E4M3) and expands them to FP16.
// Each cast input beat becomes two FP16 output beats toward the X/W/Y buffers.
// When cast is off, the stage is a registered pass-through with a valid/ready handshake.
// PARAMETERS
// DATA_W    256  beat width in bits; multiple of 16
// NE        DATA_W/16 (localparam)  FP16 lanes per output beat; an input beat holds 2*NE FP8 elements
// PORTS
// clk_i         in   1       clock
// rst_i         in   1       synchronous, active-high reset
// clear_i       in   1       synchronous soft clear, same effect as rst_i
// cast_i        in   1       1: widen FP8->FP16; 0: pass-through; sampled with the input beat
// src_fmt_i     in   1       0: E5M2 (bias 15); 1: E4M3 IEEE-like (bias 7); sampled with the input beat
// src_valid_i   in   1       input beat valid
// src_ready_o   out  1       input beat accepted when src_valid_i & src_ready_o
// src_data_i    in   DATA_W  packed input; element k at bits [8k+:8]
// dst_valid_o   out  1       output beat valid
// dst_ready_i   in   1       downstream ready
// dst_data_o    out  DATA_W  output beat; FP16 lane j at bits [16j+:16]
// nan_seen_o    out  1       sticky: a NaN input was widened (REDMULE_CASTIN_STATUS_EN only)
// BEHAVIOUR
// - Reset/clear: state=EMPTY, dst_valid_o=0, dst_data_o=0, holding buffer=0, nan_seen_o=0.
// - FSM states: EMPTY (no beat held), LO (beat held; first or only output pending),
//   HI (cast beat held; second output pending).
// - EMPTY + accept: latch data, cast_i, and fmt; go to LO. dst_valid_o rises the next cycle (latency 1).
// - LO + dst handshake: cast=0 -> beat done; cast=1 -> go to HI.
// - HI + dst handshake -> beat done.
// - Beat done: go to EMPTY, or reload directly into LO if a new beat is accepted the same cycle.
// - Output hold: dst_valid_o held high and dst_data_o held stable until dst_ready_i;
//   no output is ever dropped.
// - src_ready_o = EMPTY | (dst_ready_i & (HI | (LO & !cast_held))).
//   This is combinational on dst_ready_i, with no combinational path from src_valid_i.
// - Throughput: pass-through accepts 1 beat per cycle; cast accepts 1 beat per 2 cycles.
// - Output data by state:
//   - pass-through: dst_data_o = held beat, unmodified.
//   - LO, cast: lane j = widen(element j).
//   - HI, cast: lane j = widen(element NE+j).
// - widen E5M2: {b,8'h00}, exact; NaN payload preserved.
// - widen E4M3 {s,e[3:0],m[2:0]}:
//   - e=0,m=0 -> {s,15'h0}.
//   - normal -> {s, e+5'd8, m, 7'b0}.
//   - subnormal: m=001 -> {s,5'd6,10'h0}; m=01x -> {s,5'd7,x,9'h0}; m=1xy -> {s,5'd8,x,y,8'h0}.
//   - e=15,m=0 -> {s,15'h7C00}.
//   - e=15,m!=0 -> 16'h7E00 (canonical NaN, sign dropped).
// - Changing cast_i/src_fmt_i while a beat is held has no effect on that beat.
// - rst_i/clear_i mid-operation (LO or HI): the held beat is discarded, dst_valid_o=0 next cycle.
//   clear_i together with src_valid_i: the input is NOT accepted (src_ready_o=0 during clear).
// CONFIGURATION
// REDMULE_CASTIN_STATUS_EN defined:
//   - nan_seen_o sets one cycle after any output beat containing a widened NaN lane is
//     handshaked (E5M2 e=31,m!=0 or E4M3 e=15,m!=0).
//   - nan_seen_o is sticky until rst_i/clear_i.
// Not defined: port nan_seen_o is absent and no NaN detection logic is built.
// TESTING
// - Pass-through: cast_i=0, 4 back-to-back beats, dst_ready_i=1 -> 4 identical beats,
//   1-cycle latency, src_ready_o stays 1.
// - E4M3 cast: element0=0x38, element1=0x01, element2=0x80, element3=0x78, element4=0x7F
//   -> lanes 0x3C00, 0x1800, 0x8000, 0x7C00, 0x7E00.
// - E5M2 cast: element0=0x3C, element NE=0xC0 -> beat0 lane0=0x3C00, beat1 lane0=0xC000;
//   src_ready_o=0 in LO, 1 in HI.
// - Backpressure: dst_ready_i=0 for 5 cycles in HI -> dst_data_o stable, no new beat
//   accepted; release -> HI beat, then next beat.
// - clear_i asserted in HI with src_valid_i=1 -> dst_valid_o=0 next cycle, input not taken,
//   EMPTY; next beat processed normally.
// - STATUS_EN: NaN element in a held beat -> nan_seen_o=1 after the handshake, stays 1
//   until clear_i.

Source files
------------

// File: rtl/redmule_castin_stream.sv
// Load-path cast stage: widens packed FP8 (E5M2/E4M3) beats into two FP16 beats, or passes beats through.
// Latency 1 cycle from accept to dst_valid_o; a cast beat occupies the stage for two output beats.
// Output is held until dst_ready_i; src_ready_o is combinational on dst_ready_i only. Option: REDMULE_CASTIN_STATUS_EN.
module redmule_castin_stream #(
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              cast_i,
  input  logic              src_fmt_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  input  logic [DATA_W-1:0] src_data_i,
  output logic              dst_valid_o,
  input  logic              dst_ready_i,
  output logic [DATA_W-1:0] dst_data_o
`ifdef REDMULE_CASTIN_STATUS_EN
  ,
  output logic              nan_seen_o
`endif
);

  localparam int unsigned NE     = DATA_W / 16;
  localparam int unsigned HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } state_t;

  state_t              state_q;
  logic [HALF_W-1:0]   hold_q;
  logic                cast_q;
  logic                fmt_q;
  logic                accept;
  logic                dst_hs;
  logic                beat_done;

  // One FP8 element to FP16; fmt=0 is E5M2 (exact shift), fmt=1 is E4M3 with bias 7.
  function automatic logic [15:0] widen(input logic [7:0] b, input logic fmt);
    logic [15:0] r;
    r = {b, 8'h00};
    if (fmt) begin
      if (b[6:3] == 4'h0) begin
        if (b[2])      r = {b[7], 5'd8, b[1:0], 8'h00};
        else if (b[1]) r = {b[7], 5'd7, b[0], 9'h000};
        else if (b[0]) r = {b[7], 5'd6, 10'h000};
        else           r = {b[7], 15'h0000};
      end else if (b[6:3] == 4'hF) begin
        if (b[2:0] == 3'b000) r = {b[7], 15'h7C00};
        else                  r = 16'h7E00;
      end else begin
        r = {b[7], {1'b0, b[6:3]} + 5'd8, b[2:0], 7'h00};
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] widen_half(input logic [HALF_W-1:0] h, input logic fmt);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int j = 0; j < int'(NE); j++) begin
      r[16*j +: 16] = widen(h[8*j +: 8], fmt);
    end
    return r;
  endfunction

  assign src_ready_o = !rst_i && !clear_i &&
                       ((state_q == EMPTY) ||
                        (dst_ready_i && ((state_q == HI) || ((state_q == LO) && !cast_q))));

  assign accept    = src_valid_i && src_ready_o;
  assign dst_hs    = dst_valid_o && dst_ready_i;
  assign beat_done = dst_hs && ((state_q == HI) || ((state_q == LO) && !cast_q));

  // A new beat can only be accepted in EMPTY or on the same edge the held beat finishes,
  // so reload takes priority over the plain beat_done drain.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      cast_q      <= 1'b0;
      fmt_q       <= 1'b0;
      dst_valid_o <= 1'b0;
      dst_data_o  <= '0;
    end else if (accept) begin
      state_q     <= LO;
      hold_q      <= src_data_i[DATA_W-1:HALF_W];
      cast_q      <= cast_i;
      fmt_q       <= src_fmt_i;
      dst_valid_o <= 1'b1;
      dst_data_o  <= cast_i ? widen_half(src_data_i[HALF_W-1:0], src_fmt_i) : src_data_i;
    end else if (beat_done) begin
      state_q     <= EMPTY;
      dst_valid_o <= 1'b0;
    end else if (dst_hs && (state_q == LO)) begin
      state_q    <= HI;
      dst_data_o <= widen_half(hold_q, fmt_q);
    end
  end

`ifdef REDMULE_CASTIN_STATUS_EN
  logic nan_lo_q;
  logic nan_hi_q;

  function automatic logic is_nan(input logic [7:0] b, input logic fmt);
    if (fmt) return (b[6:3] == 4'hF) && (b[2:0] != 3'b000);
    else     return (b[6:2] == 5'h1F) && (b[1:0] != 2'b00);
  endfunction

  function automatic logic half_has_nan(input logic [HALF_W-1:0] h, input logic fmt);
    logic r;
    r = 1'b0;
    for (int j = 0; j < int'(NE); j++) begin
      r = r | is_nan(h[8*j +: 8], fmt);
    end
    return r;
  endfunction

  // NaN flags are captured per half at load so the flag tracks the beat actually handed off.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      nan_lo_q   <= 1'b0;
      nan_hi_q   <= 1'b0;
      nan_seen_o <= 1'b0;
    end else begin
      if (dst_hs && cast_q && ((state_q == LO) ? nan_lo_q : nan_hi_q)) begin
        nan_seen_o <= 1'b1;
      end
      if (accept) begin
        nan_lo_q <= half_has_nan(src_data_i[HALF_W-1:0], src_fmt_i);
        nan_hi_q <= half_has_nan(src_data_i[DATA_W-1:HALF_W], src_fmt_i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_redmule_castin_stream.sv
// Directed self-checking bench for redmule_castin_stream (DATA_W=256, NE=16).
module tb_redmule_castin_stream;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          cast = 1'b0;
  logic          fmt = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] src_data = '0;
  logic          dst_valid;
  logic          dst_ready = 1'b0;
  logic [DW-1:0] dst_data;
`ifdef REDMULE_CASTIN_STATUS_EN
  logic          nan_seen;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] E4M3_IN  = {216'h0, 8'h7F, 8'h78, 8'h80, 8'h01, 8'h38};
  localparam logic [DW-1:0] E4M3_LO  = {176'h0, 16'h7E00, 16'h7C00, 16'h8000, 16'h1800, 16'h3C00};
  localparam logic [DW-1:0] E5M2_IN  = {120'h0, 8'hC0, 120'h0, 8'h3C};
  localparam logic [DW-1:0] E5M2_LO  = {240'h0, 16'h3C00};
  localparam logic [DW-1:0] E5M2_HI  = {240'h0, 16'hC000};
  localparam logic [DW-1:0] BEAT_Q   = {8{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] BEAT_R   = {16{16'h1234}};

  always #5 clk = ~clk;

  redmule_castin_stream #(.DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .cast_i      (cast),
    .src_fmt_i   (fmt),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .src_data_i  (src_data),
    .dst_valid_o (dst_valid),
    .dst_ready_i (dst_ready),
    .dst_data_o  (dst_data)
`ifdef REDMULE_CASTIN_STATUS_EN
    ,
    .nan_seen_o  (nan_seen)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dst_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dst_valid); end
    checks++; if (dst_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", dst_data); end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset got=%b exp=0", src_ready); end
`ifdef REDMULE_CASTIN_STATUS_EN
    checks++; if (nan_seen !== 1'b0) begin errors++; $display("FAIL reset_nan got=%b exp=0", nan_seen); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_empty got=%b exp=1", src_ready); end
    tick();
  endtask

  task automatic test_passthru;
    logic [DW-1:0] pt [4];
    pt[0] = {8{32'h1122_3344}};
    pt[1] = {8{32'hCAFE_F00D}};
    pt[2] = {16{16'h8001}};
    pt[3] = {32{8'h5A}};
    cast = 1'b0;
    dst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1;
      src_data  = pt[i];
      #1;
      checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL pt_ready beat=%0d got=%b exp=1", i, src_ready); end
      if (i > 0) begin
        checks++; if (dst_valid !== 1'b1 || dst_data !== pt[i-1]) begin
          errors++; $display("FAIL pt_out beat=%0d valid=%b got=%h exp=%h", i-1, dst_valid, dst_data, pt[i-1]);
        end
      end
      tick();
    end
    src_valid = 1'b0;
    #1;
    checks++; if (dst_valid !== 1'b1 || dst_data !== pt[3]) begin
      errors++; $display("FAIL pt_out beat=3 valid=%b got=%h exp=%h", dst_valid, dst_data, pt[3]);
    end
    tick();
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL pt_drain got=%b exp=0", dst_valid); end
  endtask

  task automatic test_e4m3;
    fmt = 1'b1;
    cast = 1'b1;
    src_valid = 1'b1;
    src_data = E4M3_IN;
    dst_ready = 1'b1;
    tick();
    src_valid = 1'b0;
    cast = 1'b0;   // must not affect the held beat
    fmt = 1'b0;
    #1;
    checks++; if (dst_valid !== 1'b1 || dst_data !== E4M3_LO) begin
      errors++; $display("FAIL e4m3_lo valid=%b got=%h exp=%h", dst_valid, dst_data, E4M3_LO);
    end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL e4m3_ready_lo got=%b exp=0", src_ready); end
    tick();
    #1;
    checks++; if (dst_valid !== 1'b1 || dst_data !== '0) begin
      errors++; $display("FAIL e4m3_hi valid=%b got=%h exp=0", dst_valid, dst_data);
    end
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL e4m3_ready_hi got=%b exp=1", src_ready); end
    tick();
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL e4m3_drain got=%b exp=0", dst_valid); end
  endtask

  task automatic test_backpressure;
    fmt = 1'b0;
    cast = 1'b1;
    src_valid = 1'b1;
    src_data = E5M2_IN;
    dst_ready = 1'b1;
    tick();
    src_valid = 1'b0;
    #1;
    checks++; if (dst_valid !== 1'b1 || dst_data !== E5M2_LO) begin
      errors++; $display("FAIL e5m2_lo valid=%b got=%h exp=%h", dst_valid, dst_data, E5M2_LO);
    end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL e5m2_ready_lo got=%b exp=0", src_ready); end
    tick();
    src_valid = 1'b1;
    src_data = BEAT_Q;
    cast = 1'b0;
    dst_ready = 1'b0;
    #1;
    checks++; if (dst_valid !== 1'b1 || dst_data !== E5M2_HI) begin
      errors++; $display("FAIL e5m2_hi valid=%b got=%h exp=%h", dst_valid, dst_data, E5M2_HI);
    end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall0 got=%b exp=0", src_ready); end
    for (int k = 1; k < 5; k++) begin
      tick();
      #1;
      checks++; if (dst_valid !== 1'b1 || dst_data !== E5M2_HI || src_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d valid=%b ready=%b got=%h exp=%h", k, dst_valid, src_ready, dst_data, E5M2_HI);
      end
    end
    dst_ready = 1'b1;
    #1;
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", src_ready); end
    tick();
    src_valid = 1'b0;
    #1;
    checks++; if (dst_valid !== 1'b1 || dst_data !== BEAT_Q) begin
      errors++; $display("FAIL bp_next valid=%b got=%h exp=%h", dst_valid, dst_data, BEAT_Q);
    end
    tick();
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", dst_valid); end
  endtask

  task automatic test_clear;
    fmt = 1'b0;
    cast = 1'b1;
    src_valid = 1'b1;
    src_data = E5M2_IN;
    dst_ready = 1'b1;
    tick();
    src_valid = 1'b0;
    tick();
    #1;
    checks++; if (dst_valid !== 1'b1 || dst_data !== E5M2_HI) begin
      errors++; $display("FAIL clr_pre_hi valid=%b got=%h exp=%h", dst_valid, dst_data, E5M2_HI);
    end
    clear = 1'b1;
    src_valid = 1'b1;
    src_data = BEAT_Q;
    cast = 1'b0;
    #1;
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got=%b exp=0", src_ready); end
    tick();
    clear = 1'b0;
    src_valid = 1'b0;
    dst_ready = 1'b0;
    #1;
    checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", dst_valid); end
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL clr_empty_ready got=%b exp=1", src_ready); end
    src_valid = 1'b1;
    src_data = BEAT_R;
    dst_ready = 1'b1;
    tick();
    src_valid = 1'b0;
    #1;
    checks++; if (dst_valid !== 1'b1 || dst_data !== BEAT_R) begin
      errors++; $display("FAIL clr_next valid=%b got=%h exp=%h", dst_valid, dst_data, BEAT_R);
    end
    tick();
  endtask

`ifdef REDMULE_CASTIN_STATUS_EN
  task automatic test_nan_status;
    logic [DW-1:0] nan_in;
    logic [DW-1:0] nan_hi;
    nan_in = {120'h0, 8'h7D, 128'h0};
    nan_hi = {240'h0, 16'h7D00};
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    checks++; if (nan_seen !== 1'b0) begin errors++; $display("FAIL nan_after_clear got=%b exp=0", nan_seen); end
    fmt = 1'b0;
    cast = 1'b1;
    src_valid = 1'b1;
    src_data = nan_in;
    dst_ready = 1'b1;
    tick();
    src_valid = 1'b0;
    #1;
    checks++; if (nan_seen !== 1'b0) begin errors++; $display("FAIL nan_before_hs got=%b exp=0", nan_seen); end
    tick();
    #1;
    checks++; if (nan_seen !== 1'b0 || dst_data !== nan_hi) begin
      errors++; $display("FAIL nan_lo_hs flag=%b got=%h exp=%h", nan_seen, dst_data, nan_hi);
    end
    tick();
    #1;
    checks++; if (nan_seen !== 1'b1) begin errors++; $display("FAIL nan_set got=%b exp=1", nan_seen); end
    repeat (3) tick();
    checks++; if (nan_seen !== 1'b1) begin errors++; $display("FAIL nan_sticky got=%b exp=1", nan_seen); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    checks++; if (nan_seen !== 1'b0) begin errors++; $display("FAIL nan_cleared got=%b exp=0", nan_seen); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthru();
    test_e4m3();
    test_backpressure();
    test_clear();
`ifdef REDMULE_CASTIN_STATUS_EN
    test_nan_status();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
